// File: rtl/dll_scheduler.sv
// dll_scheduler: time-shares one DLL discriminator among tracking channels.
// Buffers one early/late pair per channel, issues round-robin per slot.
module dll_scheduler #(
    parameter int NUM_CHANNELS     = 4,
    parameter int CHANNEL_ID_WIDTH = 2,
    parameter int I2Q2_WIDTH       = 38,
    parameter int DPHI_WIDTH       = 16,
    parameter int SLOT_CYCLES      = 8
) (
    input  logic                        clk,
    input  logic                        global_reset_n,
    input  logic                        sched_enable,
    input  logic                        req_valid,
    input  logic [CHANNEL_ID_WIDTH-1:0] req_tag,
    input  logic [I2Q2_WIDTH-1:0]       req_i2q2_early,
    input  logic [I2Q2_WIDTH-1:0]       req_i2q2_late,
    output logic                        dll_issue,
    output logic [CHANNEL_ID_WIDTH-1:0] dll_tag,
    output logic [I2Q2_WIDTH-1:0]       dll_i2q2_early,
    output logic [I2Q2_WIDTH-1:0]       dll_i2q2_late,
    input  logic                        dll_result_ready,
    input  logic [CHANNEL_ID_WIDTH-1:0] dll_result_tag,
    input  logic [DPHI_WIDTH-1:0]       dll_delta_phase_increment,
    output logic                        result_valid,
    output logic [CHANNEL_ID_WIDTH-1:0] result_tag,
    output logic [DPHI_WIDTH-1:0]       result_dphi,
    output logic [NUM_CHANNELS-1:0]     pending_mask,
    output logic [NUM_CHANNELS-1:0]     inflight_mask,
    output logic                        overwrite_err,
    output logic                        spurious_err
);

    localparam int CW   = CHANNEL_ID_WIDTH;
    localparam int CNTW = $clog2(SLOT_CYCLES);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0]   LAST_CH  = CW'(NUM_CHANNELS - 1);

    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]           last_grant_q, last_grant_d;
    logic [NUM_CHANNELS-1:0] pending_q, pending_d;
    logic [NUM_CHANNELS-1:0] inflight_q, inflight_d;
    logic [I2Q2_WIDTH-1:0]   early_buf_q [NUM_CHANNELS];
    logic [I2Q2_WIDTH-1:0]   late_buf_q  [NUM_CHANNELS];

    logic                    issue_q;
    logic [CW-1:0]           dll_tag_q;
    logic [I2Q2_WIDTH-1:0]   dll_early_q, dll_late_q;
    logic                    res_valid_q;
    logic [CW-1:0]           res_tag_q;
    logic [DPHI_WIDTH-1:0]   res_dphi_q;
    logic                    ovf_err_q, spur_err_q;

    logic                    slot_end;
    logic                    grant_vld;
    logic [CW-1:0]           grant_idx;
    logic [NUM_CHANNELS-1:0] grant_oh, req_oh, res_oh;
    logic                    res_match, ovf_set, spur_set;
    int                      idx;

    assign slot_end = (cnt_q == CNT_LAST);

    // Decode request and result tags; out-of-range tags decode to nothing.
    always_comb begin
        req_oh = '0;
        res_oh = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            req_oh[i] = req_valid && (req_tag == CW'(i));
            res_oh[i] = dll_result_ready && (dll_result_tag == CW'(i));
        end
    end

    // Round-robin pick starting one past the last granted channel.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_grant_q;
        grant_oh  = '0;
        idx       = 0;
        if (slot_end && sched_enable) begin
            for (int i = 1; i <= NUM_CHANNELS; i++) begin
                idx = (int'(last_grant_q) + i) % NUM_CHANNELS;
                if (!grant_vld && pending_q[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = CW'(idx);
                end
            end
        end
        if (grant_vld) grant_oh[grant_idx] = 1'b1;
    end

    // Next-state: a same-cycle request re-arms a channel being granted,
    // and a same-cycle issue wins over a result clearing inflight.
    always_comb begin
        cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
        pending_d    = (pending_q & ~grant_oh) | req_oh;
        inflight_d   = (inflight_q & ~res_oh) | grant_oh;
        last_grant_d = grant_vld ? grant_idx : last_grant_q;
        res_match    = |(res_oh & inflight_q);
        ovf_set      = |(req_oh & pending_q & ~grant_oh);
        spur_set     = dll_result_ready && !res_match;
    end

    // Control state: slot counter, masks, arbitration pointer, error flags.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            cnt_q        <= '0;
            last_grant_q <= LAST_CH;
            pending_q    <= '0;
            inflight_q   <= '0;
            ovf_err_q    <= 1'b0;
            spur_err_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            inflight_q   <= inflight_d;
            ovf_err_q    <= ovf_err_q | ovf_set;
            spur_err_q   <= spur_err_q | spur_set;
        end
    end

    // Per-channel operand buffers; a new request replaces the old pair.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                early_buf_q[i] <= '0;
                late_buf_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (req_oh[i]) begin
                    early_buf_q[i] <= req_i2q2_early;
                    late_buf_q[i]  <= req_i2q2_late;
                end
            end
        end
    end

    // DLL issue port: operands are held until the next grant.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            issue_q     <= 1'b0;
            dll_tag_q   <= '0;
            dll_early_q <= '0;
            dll_late_q  <= '0;
        end else begin
            issue_q <= grant_vld;
            if (grant_vld) begin
                dll_tag_q   <= grant_idx;
                dll_early_q <= early_buf_q[grant_idx];
                dll_late_q  <= late_buf_q[grant_idx];
            end
        end
    end

    // Matched-result port: only results for in-flight channels pass.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_dphi_q  <= '0;
        end else begin
            res_valid_q <= res_match;
            if (res_match) begin
                res_tag_q  <= dll_result_tag;
                res_dphi_q <= dll_delta_phase_increment;
            end
        end
    end

    assign dll_issue      = issue_q;
    assign dll_tag        = dll_tag_q;
    assign dll_i2q2_early = dll_early_q;
    assign dll_i2q2_late  = dll_late_q;
    assign result_valid   = res_valid_q;
    assign result_tag     = res_tag_q;
    assign result_dphi    = res_dphi_q;
    assign pending_mask   = pending_q;
    assign inflight_mask  = inflight_q;
    assign overwrite_err  = ovf_err_q;
    assign spurious_err   = spur_err_q;

endmodule

// File: doc/dll_scheduler.md
# dll_scheduler

Shares one `dll` discriminator instance among `NUM_CHANNELS` tracking channels. Channels post early/late I2Q2 pairs at any time. The scheduler buffers one pair per channel and issues them to the DLL at fixed slot boundaries in round-robin order. It then matches tagged DLL results back to in-flight channels. It sits between the channel accumulators and the DLL, and its result outputs feed the per-channel code NCO update.

## Interface
Parameters:
- `NUM_CHANNELS`, 4: number of channels sharing the DLL.
- `CHANNEL_ID_WIDTH`, 2: tag width; must satisfy 2^`CHANNEL_ID_WIDTH` >= `NUM_CHANNELS`.
- `I2Q2_WIDTH`, 38: width of each I2Q2 operand.
- `DPHI_WIDTH`, 16: DLL delta phase increment width.
- `SLOT_CYCLES`, 8: clk cycles per DLL issue slot; must be >= 2.

Ports:
- `clk` in 1: system clock; the only clock.
- `global_reset_n` in 1: asynchronous, active-low reset.
- `sched_enable` in 1: when low, no new issues; pending requests are retained.
- `req_valid` in 1: request strobe, one cycle per request.
- `req_tag` in `CHANNEL_ID_WIDTH`: requesting channel.
- `req_i2q2_early`, `req_i2q2_late` in `I2Q2_WIDTH`: operands.
- `dll_issue` out 1: one-cycle strobe marking a new operation.
- `dll_tag` out `CHANNEL_ID_WIDTH`: channel of the current operation.
- `dll_i2q2_early`, `dll_i2q2_late` out `I2Q2_WIDTH`: operands, held until the next issue.
- `dll_result_ready` in 1: DLL result strobe.
- `dll_result_tag` in `CHANNEL_ID_WIDTH`: DLL result channel.
- `dll_delta_phase_increment` in `DPHI_WIDTH`: DLL result value.
- `result_valid` out 1: matched-result strobe.
- `result_tag` out `CHANNEL_ID_WIDTH`: channel of the matched result.
- `result_dphi` out `DPHI_WIDTH`: value of the matched result.
- `pending_mask` out `NUM_CHANNELS`: buffered, not-yet-issued requests.
- `inflight_mask` out `NUM_CHANNELS`: issued, awaiting result.
- `overwrite_err` out 1: sticky; set when a pending request is replaced.
- `spurious_err` out 1: sticky; set when a result arrives for a channel not in flight.

## Operation
- **Request capture.** On `req_valid` with `req_tag` < `NUM_CHANNELS`:
  - Store the operands in that channel's buffer and set `pending[tag]`.
  - If `pending[tag]` was already set, the new operands replace the old ones and `overwrite_err` is set.
  - A `req_tag` >= `NUM_CHANNELS` is ignored.
  - A request for a channel that is in flight is legal and becomes pending.
- **Slot counter.** Counts 0..`SLOT_CYCLES`-1 and wraps. Cycle `SLOT_CYCLES`-1 is the slot boundary.
- **Arbitration at the slot boundary.** Applies when `sched_enable`=1 and `pending_mask`≠0.
  - Search starts at `last_grant`+1 modulo `NUM_CHANNELS` and takes the first pending channel.
  - Register that channel's buffered operands and tag onto the `dll_*` outputs and pulse `dll_issue`.
  - Clear its pending bit, set its inflight bit, and update `last_grant`.
  - If nothing is pending, no issue occurs and the `dll_*` outputs hold their values.
- **Result match.** On `dll_result_ready`:
  - If `inflight[dll_result_tag]` is set: register the tag and value onto `result_*`, pulse `result_valid`, and clear the inflight bit.
  - Otherwise: drop the result and set `spurious_err`.
- **Simultaneous events.**
  - Request and grant for the same channel in one cycle: the grant issues the old operands; the new request remains pending.
  - Result clear and issue for the same channel in one cycle: the inflight bit stays set.
  - Request for channel A while channel B is granted: both take effect.
- **Error flags.** Sticky until reset only.

## Timing
- **Reset values.** On assertion of `global_reset_n`=0:
  - Counter = 0, `last_grant` = `NUM_CHANNELS`-1, so channel 0 has first priority.
  - All masks, strobes, `dll_*` outputs, `result_*` outputs and error flags = 0.
- **Latencies.**
  - Request at cycle t → `pending_mask` bit visible at t+1.
  - Slot boundary at cycle s → `dll_issue` and `dll_*` operands valid at s+1.
  - Issue rate is at most one per `SLOT_CYCLES` cycles.
  - `dll_result_ready` at cycle r → `result_valid` at r+1.
- **Operand hold.** `dll_*` operands are stable for at least `SLOT_CYCLES` cycles after each issue.
- **Mid-operation reset.** Pending and inflight state is discarded. Results arriving after reset are flagged as spurious.

## Test plan
- **Single request.** Reset, then `req_valid` with tag 2, early=100, late=60. → The first slot boundary yields `dll_issue` with tag 2, 100/60 and `inflight_mask`=4'b0100. A DLL result with tag 2 and dphi=16'h0123 → `result_valid` one cycle later with tag 2 and 16'h0123; `inflight_mask`=0.
- **Round-robin fairness.** Keep all 4 channels re-requesting continuously, `SLOT_CYCLES`=8. → Issues go to channels 0, 1, 2, 3, 0, … exactly 8 cycles apart.
- **Overwrite.** Two requests for channel 1 (early 10, then 20) before any slot. → The issued early is 20 and `overwrite_err`=1.
- **Spurious result.** `dll_result_ready` with tag 3 while channel 3 is not in flight. → No `result_valid`; `spurious_err`=1.
- **Collisions.**
  - A request for channel 0 on its grant cycle → the old operands issue and `pending[0]` remains 1.
  - `sched_enable`=0 for 3 slots → no issues.
  - Re-enable → issue at the next boundary.
- **Reset mid-operation.** Assert `global_reset_n` low with 2 channels in flight. → All masks clear immediately; later results for those tags set `spurious_err`.
